// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants: opcodes, command type codes, error codes
// and the encoder state type.
package rv_isa_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] CMD_LOAD   = 3'd0;
   localparam logic [2:0] CMD_STORE  = 3'd1;
   localparam logic [2:0] CMD_RTYPE  = 3'd2;
   localparam logic [2:0] CMD_BRANCH = 3'd3;
   localparam logic [2:0] CMD_ITYPE  = 3'd4;
   localparam logic [2:0] CMD_JAL    = 3'd5;
   localparam logic [2:0] CMD_JALR   = 3'd6;
   localparam logic [2:0] CMD_RSVD   = 3'd7;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_BAD_TYPE  = 2'd1;
   localparam logic [1:0] ERR_IMM_RANGE = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_ERR
   } enc_state_e;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer with immediate range checking.
// Purely a function of the command fields; the top decides whether to use it.
module rv_instr_pack
   import rv_isa_pkg::*;
(
   input  logic [2:0]  cmd_type_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7b5_i,
   input  logic [31:0] imm_i,
   output logic [31:0] instr_o,
   output logic        bad_type_o,
   output logic        imm_err_o
);

   logic signed [31:0] immS;
   logic               iRangeOk;
   logic               branchOk;
   logic               jalOk;

   assign immS     = imm_i;
   assign iRangeOk = (immS >= -32'sd2048) && (immS <= 32'sd2047);
   assign branchOk = (immS >= -32'sd4096) && (immS <= 32'sd4094) && !imm_i[0];
   assign jalOk    = (immS >= -32'sd1048576) && (immS <= 32'sd1048574) && !imm_i[0];

   // Shift-immediate ITYPE carries funct7[5] in the upper immediate slot.
   always_comb begin
      instr_o    = '0;
      bad_type_o = 1'b0;
      imm_err_o  = 1'b0;
      case (cmd_type_i)
         CMD_LOAD: begin
            instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
            imm_err_o = !iRangeOk;
         end
         CMD_STORE: begin
            instr_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
            imm_err_o = !iRangeOk;
         end
         CMD_RTYPE: begin
            instr_o = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OPC_RTYPE};
         end
         CMD_BRANCH: begin
            instr_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], OPC_BRANCH};
            imm_err_o = !branchOk;
         end
         CMD_ITYPE: begin
            if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
               instr_o = {1'b0, funct7b5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_ITYPE};
            end else begin
               instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_ITYPE};
            end
            imm_err_o = !iRangeOk;
         end
         CMD_JAL: begin
            instr_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            imm_err_o = !jalOk;
         end
         CMD_JALR: begin
            instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
            imm_err_o = !iRangeOk;
         end
         default: begin
            bad_type_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams symbolic commands into instruction memory as RV32I words.
// Holds the load FSM, the write pointer and the registered memory write port.
module instr_stream_encoder
   import rv_isa_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_type,
   input  logic [4:0]    cmd_rd,
   input  logic [4:0]    cmd_rs1,
   input  logic [4:0]    cmd_rs2,
   input  logic [2:0]    cmd_funct3,
   input  logic          cmd_funct7b5,
   input  logic [31:0]   cmd_imm,
   input  logic          cmd_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic [AW:0]   instr_count,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code
);

   localparam int          DEPTH     = 2 ** AW;
   localparam logic [AW:0] LAST_SLOT = (AW + 1)'(DEPTH - 1);

   enc_state_e    state_q, state_d;
   logic [AW:0]   ptr_q, ptr_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    errCode_q, errCode_d;

   logic [31:0]   packedInstr;
   logic          badType;
   logic          immErr;
   logic          accept;

   rv_instr_pack u_pack (
      .cmd_type_i (cmd_type),
      .rd_i       (cmd_rd),
      .rs1_i      (cmd_rs1),
      .rs2_i      (cmd_rs2),
      .funct3_i   (cmd_funct3),
      .funct7b5_i (cmd_funct7b5),
      .imm_i      (cmd_imm),
      .instr_o    (packedInstr),
      .bad_type_o (badType),
      .imm_err_o  (immErr)
   );

   assign cmd_ready = (state_q == ST_LOAD) && !start;
   assign accept    = cmd_valid && cmd_ready;

   // start always wins; a rejected command leaves memory and pointer untouched,
   // and the slot at DEPTH-1 is the last one ever written so the pointer never wraps.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      errCode_d = errCode_q;
      if (start) begin
         state_d   = ST_LOAD;
         ptr_d     = '0;
         errCode_d = ERR_NONE;
      end else if (accept) begin
         if (badType) begin
            state_d   = ST_ERR;
            errCode_d = ERR_BAD_TYPE;
         end else if (immErr) begin
            state_d   = ST_ERR;
            errCode_d = ERR_IMM_RANGE;
         end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q[AW-1:0];
            wdata_d = packedInstr;
            ptr_d   = ptr_q + (AW + 1)'(1);
            if (cmd_last) begin
               state_d = ST_DONE;
            end else if (ptr_q == LAST_SLOT) begin
               state_d   = ST_ERR;
               errCode_d = ERR_OVERFLOW;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         errCode_q <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         errCode_q <= errCode_d;
      end
   end

   assign imem_we     = we_q;
   assign imem_addr   = addr_q;
   assign imem_wdata  = wdata_q;
   assign instr_count = ptr_q;
   assign busy        = (state_q == ST_LOAD);
   assign done        = (state_q == ST_DONE);
   assign err         = (state_q == ST_ERR);
   assign err_code    = errCode_q;

endmodule
